// File: rtl/riscv_load_scoreboard_if.sv
// Decode-issue and LSU-writeback signals seen by the load scoreboard.
// The master drives issue/writeback. The slave (scoreboard) returns issue_ready_o.
interface riscv_load_scoreboard_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [2:0]            issue_use_i;
  logic [ADDR_WIDTH-1:0] raddr_a_i;
  logic [ADDR_WIDTH-1:0] raddr_b_i;
  logic [ADDR_WIDTH-1:0] raddr_c_i;
  logic                  issue_load_i;
  logic [ADDR_WIDTH-1:0] issue_waddr_i;
  logic                  lsu_wb_valid_i;
  logic [ADDR_WIDTH-1:0] lsu_wb_addr_i;

  modport master (
    output issue_valid_i, issue_use_i, raddr_a_i, raddr_b_i, raddr_c_i,
           issue_load_i, issue_waddr_i, lsu_wb_valid_i, lsu_wb_addr_i,
    input  issue_ready_o
  );

  modport slave (
    input  issue_valid_i, issue_use_i, raddr_a_i, raddr_b_i, raddr_c_i,
           issue_load_i, issue_waddr_i, lsu_wb_valid_i, lsu_wb_addr_i,
    output issue_ready_o
  );
endinterface

// File: rtl/riscv_load_scoreboard.sv
// Pending-load scoreboard in front of the register file.
// Stalls decode on RAW/WAW hazards against in-flight loads and drains them on a flush.
module riscv_load_scoreboard #(
  parameter  int ADDR_WIDTH      = 5,
  parameter  int MAX_OUTSTANDING = 2,
  localparam int NUM_WORDS       = 2**ADDR_WIDTH,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  riscv_load_scoreboard_if.slave   sb,
  input  logic                     flush_i,
  output logic [NUM_WORDS-1:0]     busy_o,
  output logic [CNT_W-1:0]         outstanding_o,
  output logic                     draining_o,
  output logic                     err_o
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [NUM_WORDS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 hazard, full, ready, acc_load, wb;

  // Hazards look only at registered busy: write data lands at the edge and is
  // not readable from the regfile until the following cycle.
  assign hazard = (sb.issue_use_i[0] & busy_q[sb.raddr_a_i])
                | (sb.issue_use_i[1] & busy_q[sb.raddr_b_i])
                | (sb.issue_use_i[2] & busy_q[sb.raddr_c_i])
                | (sb.issue_load_i   & busy_q[sb.issue_waddr_i]);
  assign full     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign ready    = (state_q == RUN) & ~flush_i & ~hazard & ~(sb.issue_load_i & full);
  assign acc_load = sb.issue_valid_i & ready & sb.issue_load_i;
  assign wb       = sb.lsu_wb_valid_i;

  assign sb.issue_ready_o = ready;
  assign busy_o           = busy_q;
  assign outstanding_o    = cnt_q;
  assign draining_o       = (state_q == DRAIN);
  assign err_o            = err_q;

  // x0 is never tracked. On a same-address wb+load, the set term wins.
  assign busy_d[0] = 1'b0;
  for (genvar i = 1; i < NUM_WORDS; i++) begin : g_busy
    assign busy_d[i] = (busy_q[i] & ~(wb & (sb.lsu_wb_addr_i == ADDR_WIDTH'(i))))
                     | (acc_load & (sb.issue_waddr_i == ADDR_WIDTH'(i)));
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (acc_load & ~wb) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (~acc_load & wb) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i)       state_d = DRAIN;
      DRAIN:   if (cnt_q == '0)   state_d = RUN;
      default:                    state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      busy_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_load_scoreboard.sv
// Directed bench for riscv_load_scoreboard: an array/counter model is checked
// against the DUT every cycle, and hand-computed literals pin the scenarios.
module tb_riscv_load_scoreboard;
  localparam int AW  = 5;
  localparam int NW  = 2**AW;
  localparam int MAX = 2;
  localparam int CW  = $clog2(MAX+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [NW-1:0] busy_o;
  logic [CW-1:0] outstanding_o;
  logic          draining_o, err_o;

  riscv_load_scoreboard_if #(.ADDR_WIDTH(AW)) bus ();

  riscv_load_scoreboard #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst), .sb(bus.slave), .flush_i(flush_i),
    .busy_o(busy_o), .outstanding_o(outstanding_o),
    .draining_o(draining_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: a set of pending registers plus a load count ----
  bit pend_m[NW];
  int cnt_m;
  bit err_m, drain_m, model_live;

  function automatic bit m_ready();
    bit haz;
    haz = (bus.issue_use_i[0] && pend_m[bus.raddr_a_i]) ||
          (bus.issue_use_i[1] && pend_m[bus.raddr_b_i]) ||
          (bus.issue_use_i[2] && pend_m[bus.raddr_c_i]) ||
          (bus.issue_load_i   && pend_m[bus.issue_waddr_i]);
    return !drain_m && !flush_i && !haz && !(bus.issue_load_i && cnt_m == MAX);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      cnt_m = 0; err_m = 0; drain_m = 0; model_live = 1;
    end else if (model_live) begin
      bit acc, w;
      int old_cnt;
      acc = bus.issue_valid_i && m_ready() && bus.issue_load_i;
      w   = bus.lsu_wb_valid_i;
      old_cnt = cnt_m;
      if (w && old_cnt == 0 && !acc) err_m = 1;
      cnt_m = old_cnt + int'(acc) - int'(w);
      if (cnt_m < 0) cnt_m = 0;
      if (w) pend_m[bus.lsu_wb_addr_i] = 1'b0;
      if (acc && bus.issue_waddr_i != 0) pend_m[bus.issue_waddr_i] = 1'b1;
      if (!drain_m && flush_i) drain_m = 1;
      else if (drain_m && old_cnt == 0) drain_m = 0;
    end
  end

  always @(negedge clk) begin
    if (model_live && !rst) begin
      logic [NW-1:0] exp_busy;
      for (int i = 0; i < NW; i++) exp_busy[i] = pend_m[i];
      chk("model_ready", int'(bus.issue_ready_o), int'(m_ready()));
      n_cmp++;
      if (busy_o !== exp_busy) begin
        n_bad++;
        $display("FAIL model_busy: got %h expected %h (t=%0t)", busy_o, exp_busy, $time);
      end
      chk("model_cnt",   int'(outstanding_o), cnt_m);
      chk("model_drain", int'(draining_o),    int'(drain_m));
      chk("model_err",   int'(err_o),         int'(err_m));
    end
  end

  // ---- stimulus helpers ----
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    bus.issue_valid_i = 0; bus.issue_use_i = 0; bus.issue_load_i = 0;
    bus.raddr_a_i = 0; bus.raddr_b_i = 0; bus.raddr_c_i = 0; bus.issue_waddr_i = 0;
    bus.lsu_wb_valid_i = 0; bus.lsu_wb_addr_i = 0; flush_i = 0;
  endtask

  task automatic load(input int rd);
    bus.issue_valid_i = 1; bus.issue_load_i = 1; bus.issue_use_i = 0;
    bus.issue_waddr_i = AW'(rd);
  endtask

  task automatic use_a(input int rs);
    bus.issue_valid_i = 1; bus.issue_load_i = 0; bus.issue_use_i = 3'b001;
    bus.raddr_a_i = AW'(rs);
  endtask

  task automatic wb(input int rd);
    bus.lsu_wb_valid_i = 1; bus.lsu_wb_addr_i = AW'(rd);
  endtask

  task automatic wb_off(); bus.lsu_wb_valid_i = 0; endtask

  initial begin
    idle(); rst = 1; model_live = 0;
    tick(); tick(); rst = 0;
    #1;
    chk("rst_busy",  int'(busy_o != 0), 0);
    chk("rst_cnt",   int'(outstanding_o), 0);
    chk("rst_err",   int'(err_o), 0);
    chk("rst_drain", int'(draining_o), 0);
    chk("rst_ready", int'(bus.issue_ready_o), 1);

    // 1: load x5, then RAW consumer stalls
    load(5); #1 chk("t1_ready_load", int'(bus.issue_ready_o), 1);
    tick(); idle(); use_a(5); #1;
    chk("t1_busy5", int'(busy_o[5]), 1);
    chk("t1_cnt",   int'(outstanding_o), 1);
    chk("t1_stall", int'(bus.issue_ready_o), 0);

    // 2: wb x5 releases the consumer one cycle later
    wb(5); #1 chk("t2_ready_N", int'(bus.issue_ready_o), 0);
    tick(); wb_off(); #1;
    chk("t2_ready_N1", int'(bus.issue_ready_o), 1);
    chk("t2_busy5",    int'(busy_o[5]), 0);
    chk("t2_cnt",      int'(outstanding_o), 0);

    // 3: capacity limit
    tick(); idle(); load(3); tick(); load(4); tick(); load(6); #1;
    chk("t3_cnt_full", int'(outstanding_o), 2);
    chk("t3_full",     int'(bus.issue_ready_o), 0);
    tick(); wb(3); #1 chk("t3_full_wb", int'(bus.issue_ready_o), 0);
    tick(); wb_off(); #1;
    chk("t3_release", int'(bus.issue_ready_o), 1);
    chk("t3_cnt1",    int'(outstanding_o), 1);
    tick(); idle(); wb(4); tick(); wb(6); tick(); idle(); #1;
    chk("t3_empty",  int'(outstanding_o), 0);
    chk("t3_nobusy", int'(busy_o != 0), 0);

    // 4: loads to x0 count but never mark busy
    load(0); tick(); idle();
    bus.issue_valid_i = 1; bus.issue_use_i = 3'b111; #1;
    chk("t4_ready", int'(bus.issue_ready_o), 1);
    chk("t4_busy",  int'(busy_o != 0), 0);
    chk("t4_cnt",   int'(outstanding_o), 1);
    tick(); idle(); wb(0); tick(); idle(); #1;
    chk("t4_cnt0", int'(outstanding_o), 0);
    chk("t4_err",  int'(err_o), 0);

    // 5: wb x7 and accepted load x7 in the same cycle (x0 load keeps count > 0)
    load(0); tick(); idle(); load(7); wb(7); #1;
    chk("t5_ready", int'(bus.issue_ready_o), 1);
    tick(); idle(); #1;
    chk("t5_busy7", int'(busy_o[7]), 1);
    chk("t5_cnt",   int'(outstanding_o), 1);
    chk("t5_err",   int'(err_o), 0);
    wb(7); tick(); idle(); #1;
    chk("t5_drained", int'(outstanding_o), 0);

    // 6: flush with two loads in flight
    load(3); tick(); load(4); tick(); idle(); flush_i = 1; #1;
    chk("t6_flush_ready", int'(bus.issue_ready_o), 0);
    tick(); flush_i = 0; bus.issue_valid_i = 1; #1;
    chk("t6_drain",     int'(draining_o), 1);
    chk("t6_cnt2",      int'(outstanding_o), 2);
    chk("t6_ready_dr",  int'(bus.issue_ready_o), 0);
    flush_i = 1; wb(3); tick(); flush_i = 0; wb(4); #1;
    chk("t6_drain_wb",  int'(draining_o), 1);
    chk("t6_ready_wb",  int'(bus.issue_ready_o), 0);
    tick(); wb_off(); #1;
    chk("t6_cnt0",      int'(outstanding_o), 0);
    chk("t6_still_dr",  int'(draining_o), 1);
    chk("t6_ready_c0",  int'(bus.issue_ready_o), 0);
    tick(); #1;
    chk("t6_run",       int'(draining_o), 0);
    chk("t6_ready_run", int'(bus.issue_ready_o), 1);
    idle(); flush_i = 1; tick(); flush_i = 0; #1;
    chk("t6_f0_drain", int'(draining_o), 1);
    tick(); #1 chk("t6_f0_run", int'(draining_o), 0);
    wb(9); tick(); idle(); #1;
    chk("t6_err", int'(err_o), 1);
    tick(); tick(); #1 chk("t6_err_sticky", int'(err_o), 1);
    rst = 1; tick(); rst = 0; #1;
    chk("t6_err_rst", int'(err_o), 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
